// File: rtl/pika_pkg.sv
// Shared PikaBall definitions: game state encoding and playfield geometry.
package pika_pkg;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_IN_GAME = 2'd2,
    ST_END     = 2'd3
  } game_state_t;

  // Playfield geometry in pixels (320x240 buffer); net centre sits at x=163.
  localparam int unsigned BALL_W    = 30;
  localparam int unsigned BALL_H    = 30;
  localparam int unsigned NET_POS_X = 160;
  localparam int unsigned NET_W     = 6;
  localparam int unsigned GROUND_Y  = 220;
  localparam int unsigned VBUF_W    = 320;
  localparam int unsigned VBUF_H    = 240;

  localparam int unsigned POS_W   = 12;
  localparam int unsigned SUM_W   = 13;
  localparam int unsigned SCORE_W = 4;

  // Score increment that sticks at the maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
module delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement holds at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/pika_referee.sv
// Match control: detects ball landing, awards points, sequences serve/play/end.
module pika_referee
  import pika_pkg::*;
#(
  parameter int unsigned SERVE_DELAY = 100_000_000,
  parameter int unsigned ARM_DELAY   = 4,
  parameter int unsigned WIN_SCORE   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  // Serve timer counts SERVE_DELAY-1 down to 0 so WAIT lasts exactly SERVE_DELAY cycles.
  localparam int unsigned SERVE_W    = (SERVE_DELAY > 2) ? $clog2(SERVE_DELAY) : 1;
  localparam int unsigned SERVE_LOAD = (SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0;
  localparam int unsigned ARM_W      = (ARM_DELAY > 1) ? $clog2(ARM_DELAY + 1) : 1;
  localparam int unsigned NET_MID    = NET_POS_X + NET_W / 2;

  game_state_t        r_state;
  logic               r_btn_prev;
  logic               r_who_win;
  logic               r_point_pulse;
  logic [SCORE_W-1:0] r_player_score;
  logic [SCORE_W-1:0] r_npc_score;

  logic               w_press;
  logic               w_landed;
  logic               w_left_court;
  logic               w_point;
  logic               w_match_over;
  logic               w_serve_zero;
  logic               w_arm_zero;
  logic               w_serve_load;
  logic               w_serve_dec;
  logic               w_arm_load;
  logic               w_arm_dec;
  logic [SCORE_W-1:0] w_player_next;
  logic [SCORE_W-1:0] w_npc_next;

  // Press detection, landing/side geometry and point outcome.
  assign w_press       = start_btn & ~r_btn_prev;
  assign w_landed      = (SUM_W'(Ball_Y) + SUM_W'(BALL_H)) >= SUM_W'(GROUND_Y);
  assign w_left_court  = (SUM_W'(Ball_X) + SUM_W'(BALL_W / 2)) < SUM_W'(NET_MID);
  assign w_point       = (r_state == ST_IN_GAME) && w_arm_zero && w_landed;
  assign w_player_next = sat_inc(r_player_score);
  assign w_npc_next    = sat_inc(r_npc_score);
  assign w_match_over  = w_left_court ? (w_player_next == SCORE_W'(WIN_SCORE))
                                      : (w_npc_next == SCORE_W'(WIN_SCORE));

  // Timer controls follow the state machine transitions.
  assign w_serve_load = ((r_state == ST_START) && w_press) || (w_point && !w_match_over);
  assign w_serve_dec  = (r_state == ST_WAIT);
  assign w_arm_load   = (r_state == ST_WAIT) && w_serve_zero;
  assign w_arm_dec    = (r_state == ST_IN_GAME);

  delay_timer #(.W(SERVE_W)) u_serve_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_serve_load),
    .i_load_val (SERVE_W'(SERVE_LOAD)),
    .i_dec      (w_serve_dec),
    .o_zero_c   (w_serve_zero)
  );

  delay_timer #(.W(ARM_W)) u_arm_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_arm_load),
    .i_load_val (ARM_W'(ARM_DELAY)),
    .i_dec      (w_arm_dec),
    .o_zero_c   (w_arm_zero)
  );

  // Match FSM with registered scores, winner flag and point strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_START;
      r_btn_prev     <= 1'b1;
      r_who_win      <= 1'b0;
      r_point_pulse  <= 1'b0;
      r_player_score <= '0;
      r_npc_score    <= '0;
    end else begin
      r_btn_prev    <= start_btn;
      r_point_pulse <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_press) begin
            r_player_score <= '0;
            r_npc_score    <= '0;
            r_who_win      <= 1'b0;
            r_state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_serve_zero) begin
            r_state <= ST_IN_GAME;
          end
        end
        ST_IN_GAME: begin
          if (w_point) begin
            r_point_pulse <= 1'b1;
            if (w_left_court) begin
              r_who_win      <= 1'b0;
              r_player_score <= w_player_next;
            end else begin
              r_who_win   <= 1'b1;
              r_npc_score <= w_npc_next;
            end
            r_state <= w_match_over ? ST_END : ST_WAIT;
          end
        end
        ST_END: begin
          if (w_press) begin
            r_state <= ST_START;
          end
        end
        default: r_state <= ST_START;
      endcase
    end
  end

  assign Game_state   = r_state;
  assign who_win      = r_who_win;
  assign player_score = r_player_score;
  assign npc_score    = r_npc_score;
  assign point_pulse  = r_point_pulse;

endmodule
